sram_1r1w_clr: RTL and testbench

Parametrised simple-dual-port (one write, one read) on-chip buffer for the JPEG datapath. It generalises the single-port 16384x112 store with:
- independent read and write ports
- per-lane write masking
- write-first collision bypass
- a read-valid flag
- a hardware clear sequencer that zero-fills the array after reset

It sits between the block/coefficient producers and their consumers, for example as a line buffer or as transpose storage.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_1r1w_core.sv | 32 +++
 rtl/sram_1r1w_clr.sv | 117 +++++++++++
 tb/tb_sram_1r1w_clr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and lane-mask helpers for sram_1r1w_clr
package sram_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_READY = 1'b1;

    // Widest word the mask helper supports; callers size-cast the result down.
    localparam int MAX_W = 1024;

    function automatic int lane_cnt(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic logic [MAX_W-1:0] lane_to_bit_mask(input logic [MAX_W-1:0] lane_mask,
                                                          input int lane_w);
        logic [MAX_W-1:0] v_bits;
        v_bits = '0;
        for (int i = 0; i < MAX_W; i++) begin
            v_bits[i] = lane_mask[i / lane_w];
        end
        return v_bits;
    endfunction

endpackage

// File: rtl/sram_1r1w_core.sv
// rtl/sram_1r1w_core.sv - bare 1R1W array with bit-masked write and registered read
module sram_1r1w_core #(
    parameter int DATA_W = 112,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_wbits,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read returns the pre-write contents; the top applies the write-first bypass.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wbits) | (i_wdata & i_wbits);
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_1r1w_clr.sv
// rtl/sram_1r1w_clr.sv - 1R1W buffer with clear sequencer and write-first bypass; SRAM_OUTREG_EN adds an output stage
module sram_1r1w_clr
    import sram_pkg::*;
#(
    parameter int DATA_W         = 112,
    parameter int DEPTH          = 16384,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int LANE_W         = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NLANE         = lane_cnt(DATA_W, LANE_W)
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic [NLANE-1:0]  iWrMask,
    input  logic              iRdEn,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData,
    output logic              oRdValid,
    output logic              oInitBusy
);

    localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rd_valid;
    logic              r_rd_zero;
    logic [DATA_W-1:0] r_byp_bits;
    logic [DATA_W-1:0] r_byp_data;

    logic              w_in_clear;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_go;
    logic              w_rd_go;
    logic [DATA_W-1:0] w_wr_bits;
    logic [DATA_W-1:0] w_core_rdata;
    logic [DATA_W-1:0] w_rd_data;

    assign w_in_clear    = (r_state == ST_CLEAR);
    assign w_wr_in_range = ({1'b0, iWrAddr} < (ADDR_W+1)'(DEPTH));
    assign w_rd_in_range = ({1'b0, iRdAddr} < (ADDR_W+1)'(DEPTH));
    assign w_wr_go       = !w_in_clear && iWrEn && w_wr_in_range;
    assign w_rd_go       = !w_in_clear && iRdEn;
    assign w_wr_bits     = DATA_W'(lane_to_bit_mask(MAX_W'(iWrMask), LANE_W));

    sram_1r1w_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_clk   (iClk),
        .i_we    (w_in_clear | w_wr_go),
        .i_waddr (w_in_clear ? r_cnt : iWrAddr),
        .i_wdata (w_in_clear ? '0 : iWrData),
        .i_wbits (w_in_clear ? '1 : w_wr_bits),
        .i_re    (w_rd_go & w_rd_in_range),
        .i_raddr (iRdAddr),
        .o_rdata (w_core_rdata)
    );

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
            r_byp_bits <= '0;
            r_byp_data <= '0;
        end else begin
            if (w_in_clear) begin
                r_cnt <= r_cnt + ADDR_W'(1);
                if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    r_state <= ST_READY;
                end
            end
            r_rd_valid <= w_rd_go;
            // Bypass state is captured only on accepted reads so oRdData holds between reads.
            if (w_rd_go) begin
                r_rd_zero  <= !w_rd_in_range;
                r_byp_bits <= (w_wr_go && (iWrAddr == iRdAddr)) ? w_wr_bits : '0;
                r_byp_data <= iWrData;
            end
        end
    end

    assign w_rd_data = r_rd_zero ? '0
                     : (w_core_rdata & ~r_byp_bits) | (r_byp_data & r_byp_bits);
    assign oInitBusy = w_in_clear;

`ifdef SRAM_OUTREG_EN
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_rd_valid;
            if (r_rd_valid) begin
                r_out_data <= w_rd_data;
            end
        end
    end

    assign oRdData  = r_out_data;
    assign oRdValid = r_out_valid;
`else
    assign oRdData  = w_rd_data;
    assign oRdValid = r_rd_valid;
`endif

endmodule

// File: tb/tb_sram_1r1w_clr.sv
// tb/tb_sram_1r1w_clr.sv - directed self-checking bench for sram_1r1w_clr (DEPTH=16, DATA_W=16, LANE_W=8)
module tb_sram_1r1w_clr;

`ifdef SRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        iClk;
    logic        iReset;
    logic        iWrEn;
    logic [3:0]  iWrAddr;
    logic [15:0] iWrData;
    logic [1:0]  iWrMask;
    logic        iRdEn;
    logic [3:0]  iRdAddr;
    logic [15:0] oRdData;
    logic        oRdValid;
    logic        oInitBusy;

    int n_pass;
    int n_total;

    sram_1r1w_clr #(
        .DATA_W (16),
        .DEPTH  (16),
        .LANE_W (8)
    ) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iWrEn     (iWrEn),
        .iWrAddr   (iWrAddr),
        .iWrData   (iWrData),
        .iWrMask   (iWrMask),
        .iRdEn     (iRdEn),
        .iRdAddr   (iRdAddr),
        .oRdData   (oRdData),
        .oRdValid  (oRdValid),
        .oInitBusy (oInitBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge iClk);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
        iWrEn = 1'b1; iWrAddr = a; iWrData = d; iWrMask = m;
        step();
        iWrEn = 1'b0; iWrMask = 2'b00;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp);
        iRdEn = 1'b1; iRdAddr = a;
        step();
        iRdEn = 1'b0;
        repeat (LAT - 1) step();
        chk({tag, "_valid"}, 32'(oRdValid), 32'd1);
        chk({tag, "_data"}, 32'(oRdData), 32'(exp));
        step();
        chk({tag, "_pulse"}, 32'(oRdValid), 32'd0);
        chk({tag, "_hold"}, 32'(oRdData), 32'(exp));
    endtask

    task automatic stream_read(input string tag, input logic [15:0] exp [16]);
        for (int i = 0; i < 16 + LAT; i++) begin
            if (i >= LAT) begin
                chk($sformatf("%s_v%0d", tag, i - LAT), 32'(oRdValid), 32'd1);
                chk($sformatf("%s_d%0d", tag, i - LAT), 32'(oRdData), 32'(exp[i - LAT]));
            end
            if (i < 16) begin
                iRdEn = 1'b1; iRdAddr = 4'(i);
            end else begin
                iRdEn = 1'b0;
            end
            step();
        end
        chk({tag, "_end"}, 32'(oRdValid), 32'd0);
    endtask

    // Counts cycles with oInitBusy high from the current negedge, bounded.
    task automatic count_busy(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40 && oInitBusy; i++) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        logic [15:0] zeros [16];
        logic [15:0] pat [16];
        int busy_cycles;
        logic saw_valid;

        n_pass = 0; n_total = 0;
        iReset = 1'b1; iWrEn = 1'b0; iWrAddr = '0; iWrData = '0; iWrMask = '0;
        iRdEn = 1'b0; iRdAddr = '0;
        for (int i = 0; i < 16; i++) begin
            zeros[i] = 16'h0000;
            pat[i]   = 16'hA500 + 16'(i * 17);
        end

        repeat (3) step();
        chk("rst_busy", 32'(oInitBusy), 32'd1);
        chk("rst_valid", 32'(oRdValid), 32'd0);
        chk("rst_data", 32'(oRdData), 32'h0);

        // 1. Clear window: read of addr 5 must be ignored throughout.
        iReset = 1'b0;
        iRdEn = 1'b1; iRdAddr = 4'd5;
        saw_valid = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && oInitBusy; i++) begin
            saw_valid = saw_valid | oRdValid;
            busy_cycles++;
            step();
        end
        saw_valid = saw_valid | oRdValid;
        iRdEn = 1'b0;
        chk("clear_cycles", 32'(busy_cycles), 32'd16);
        chk("clear_no_valid", 32'(saw_valid), 32'd0);
        step();
        chk("clear_no_valid_tail", 32'(oRdValid), 32'd0);
        stream_read("zero", zeros);

        // 2. Full-mask write then read.
        do_write(4'd3, 16'hABCD, 2'b11);
        do_read("wr_full", 4'd3, 16'hABCD);

        // 3. Low-lane-only write keeps the high lane.
        do_write(4'd3, 16'h1234, 2'b01);
        do_read("wr_lo", 4'd3, 16'hAB34);

        // 4. Same-cycle write/read collision, high lane only.
        do_write(4'd7, 16'h0011, 2'b11);
        iWrEn = 1'b1; iWrAddr = 4'd7; iWrData = 16'h5566; iWrMask = 2'b10;
        iRdEn = 1'b1; iRdAddr = 4'd7;
        step();
        iWrEn = 1'b0; iWrMask = 2'b00; iRdEn = 1'b0;
        repeat (LAT - 1) step();
        chk("coll_valid", 32'(oRdValid), 32'd1);
        chk("coll_data", 32'(oRdData), 32'h5511);
        step();
        do_read("coll_after", 4'd7, 16'h5511);

        // 5. Back-to-back reads across the whole array.
        for (int i = 0; i < 16; i++) do_write(4'(i), pat[i], 2'b11);
        stream_read("b2b", pat);

        // 6a. Reset at clear count 8 restarts the full clear.
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        repeat (8) step();
        chk("mid_busy_pre", 32'(oInitBusy), 32'd1);
        iReset = 1'b1;
        step();
        chk("mid_busy_rst", 32'(oInitBusy), 32'd1);
        iReset = 1'b0;
        count_busy(busy_cycles);
        chk("mid_restart_cycles", 32'(busy_cycles), 32'd16);
        do_read("mid_cleared", 4'd9, 16'h0000);

        // 6b. Reset with a read in flight discards it.
        do_write(4'd2, 16'hBEEF, 2'b11);
        iRdEn = 1'b1; iRdAddr = 4'd2;
        @(posedge iClk);
        #1;
        iRdEn = 1'b0;
        iReset = 1'b1;
        #1;
        chk("inflight_valid", 32'(oRdValid), 32'd0);
        chk("inflight_data", 32'(oRdData), 32'h0);
        step();
        chk("inflight_valid_late", 32'(oRdValid), 32'd0);
        iReset = 1'b0;
        count_busy(busy_cycles);
        chk("inflight_clear_cycles", 32'(busy_cycles), 32'd16);
        do_read("inflight_cleared", 4'd2, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
